// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-side memory responder: funct3 codes,
// responder state encoding and the latched request record.
package data_mem_responder_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } rsp_state_e;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [2:0]  funct3;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated store word and
// sign/zero-extended load value for one 32-bit memory word.
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wword,
   output logic [31:0] rvalue
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = rdata[{lane, 3'b000} +: 8];
   assign ld_half = rdata[{lane[1], 4'b0000} +: 16];

   always_comb begin
      wstrb  = 4'b0000;
      wword  = wdata;
      rvalue = 32'h0;
      // Store data is replicated across lanes so the strobe alone picks the target bytes.
      case (funct3[1:0])
         2'b00: begin
            wstrb = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            wstrb = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         default: wstrb = 4'b1111;
      endcase
      case (funct3)
         F3_LB:   rvalue = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   rvalue = {{16{ld_half[15]}}, ld_half};
         F3_LW:   rvalue = rdata;
         F3_LBU:  rvalue = {24'h0, ld_byte};
         F3_LHU:  rvalue = {16'h0, ld_half};
         default: rvalue = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: one load/store at a time against an
// internal word RAM, with wait states and a one-cycle registered response.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

   rsp_state_e  state, state_nx;
   logic [3:0]  wait_cnt;
   mem_req_t    req_q;
   logic        accept, in_err;
   logic [31:0] in_off, q_off;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_word, st_word, ld_val;
   logic [3:0]  wstrb;

   assign accept    = (state == ST_IDLE) && (req_read || req_write);
   assign in_off    = req_addr - BASE_ADDR;
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   always_comb begin
      in_err = 1'b0;
      if (req_read && req_write)
         in_err = 1'b1;
      if (req_read && !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
         in_err = 1'b1;
      if (req_write && req_funct3 > F3_SW)
         in_err = 1'b1;
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
         in_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
         in_err = 1'b1;
      // Unsigned wrap makes addresses below BASE_ADDR land far out of range too.
      if (in_off >= SPAN)
         in_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:
            if (accept) begin
               if (in_err)                state_nx = ST_RESP;
               else if (WAIT_CYCLES == 0) state_nx = ST_ACCESS;
               else                       state_nx = ST_WAIT;
            end
         ST_WAIT:   if (wait_cnt == WAIT_LAST) state_nx = ST_ACCESS;
         ST_ACCESS: state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= 4'd0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         req_q     <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (accept) begin
                  req_q     <= '{write: req_write, addr: req_addr,
                                 funct3: req_funct3, wdata: req_wdata};
                  rsp_err   <= in_err;
                  rsp_rdata <= 32'h0;
                  wait_cnt  <= 4'd0;
               end
            ST_WAIT:   wait_cnt <= wait_cnt + 4'd1;
            ST_ACCESS: if (!req_q.write) rsp_rdata <= ld_val;
            ST_RESP:   rsp_err <= 1'b0;
            default:   ;
         endcase
      end
   end

   assign q_off   = req_q.addr - BASE_ADDR;
   assign idx     = AW'(q_off >> 2);
   assign rd_word = mem[idx];

   mem_lane_align u_align (
      .funct3 (req_q.funct3),
      .lane   (req_q.addr[1:0]),
      .wdata  (req_q.wdata),
      .rdata  (rd_word),
      .wstrb  (wstrb),
      .wword  (st_word),
      .rvalue (ld_val)
   );

   // RAM is deliberately not reset; a reset edge coinciding with ACCESS drops the store.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_ACCESS && req_q.write) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases, randomized
// traffic against a byte-level memory model, back-to-back and reset cases.
module tb_data_mem_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          W    = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_read, req_write, req_ready, rsp_valid, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [2:0]  req_funct3;

   logic        z_rst, z_read, z_write, z_ready, z_valid, z_err;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic [2:0]  z_f3;

   int nchk = 0;
   int nfail = 0;
   logic [7:0] mb [int];

   data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(z_rst), .req_read(z_read), .req_write(z_write),
      .req_addr(z_addr), .req_funct3(z_f3), .req_wdata(z_wdata),
      .req_ready(z_ready), .rsp_valid(z_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
   );

   // ---------------- reference model ----------------
   function automatic logic model_err(input logic rd, input logic wr,
                                      input logic [31:0] a, input logic [2:0] f3);
      int unsigned sz;
      logic [31:0] off;
      off = a - BASE;
      if (rd && wr) return 1'b1;
      if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (wr && f3 > 3'd2) return 1'b1;
      sz = 1 << f3[1:0];
      if (a % sz != 0) return 1'b1;
      if (off >= 32'd4096) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
      int unsigned n;
      logic [31:0] v, off;
      off = a - BASE;
      n = 1 << f3[1:0];
      v = 32'h0;
      for (int i = 0; i < n; i++)
         if (mb.exists(int'(off) + i)) v = v | (32'(mb[int'(off) + i]) << (8 * i));
      if (!f3[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   function automatic void model_store(input logic [31:0] a, input logic [2:0] f3,
                                       input logic [31:0] wd);
      int unsigned n;
      logic [31:0] off;
      off = a - BASE;
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) mb[int'(off) + i] = 8'(wd >> (8 * i));
   endfunction

   // ---------------- drivers ----------------
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      nchk++;
      if (req_ready !== 1'b1) begin
         nfail++;
         $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
      end
      if (wr && !model_err(rd, wr, a, f3)) model_store(a, f3, wd);
      req_read = rd; req_write = wr; req_addr = a; req_funct3 = f3; req_wdata = wd;
      @(posedge clk);
      #1;
      req_read = 1'b0; req_write = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 40);
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic do_req0(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rdata, output int lat);
      @(negedge clk);
      z_read = rd; z_write = wr; z_addr = a; z_f3 = f3; z_wdata = wd;
      @(posedge clk);
      #1;
      z_read = 1'b0; z_write = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!z_valid && lat < 40);
      rdata = z_rdata;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; z_rst = 1'b1;
      req_read = 0; req_write = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0;
      z_read = 0; z_write = 0; z_addr = 0; z_f3 = 0; z_wdata = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0; z_rst = 1'b0;
      nchk++;
      if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
         nfail++;
         $display("FAIL reset_ctrl: ready/valid/err=%b required 100", {req_ready, rsp_valid, rsp_err});
      end
      nchk++;
      if (rsp_rdata !== 32'h0) begin
         nfail++;
         $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
      end
      nchk++;
      if ({z_ready, z_valid, z_err} !== 3'b100) begin
         nfail++;
         $display("FAIL reset_ctrl_w0: ready/valid/err=%b required 100", {z_ready, z_valid, z_err});
      end
   endtask

   task automatic test_word;
      logic [31:0] rd; logic e; int lat;
      do_req(1'b0, 1'b1, 32'h1000_0004, 3'b010, 32'hDEAD_BEEF, rd, e, lat);
      nchk++;
      if (lat !== W + 2 || e !== 1'b0 || rd !== 32'h0) begin
         nfail++;
         $display("FAIL sw_rsp: lat=%0d err=%b rdata=%h required lat=%0d err=0 rdata=0", lat, e, rd, W + 2);
      end
      do_req(1'b1, 1'b0, 32'h1000_0004, 3'b010, 32'h0, rd, e, lat);
      nchk++;
      if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || lat !== W + 2) begin
         nfail++;
         $display("FAIL lw_roundtrip: rdata=%h err=%b lat=%0d required DEADBEEF 0 %0d", rd, e, lat, W + 2);
      end
   endtask

   task automatic test_extension;
      logic [31:0] rd; logic e; int lat;
      logic [31:0] addrs [4];
      logic [2:0]  f3s   [4];
      logic [31:0] exps  [4];
      addrs = '{32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000A};
      f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
      exps  = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8070, 32'h0000_8070};
      do_req(1'b0, 1'b1, 32'h1000_0008, 3'b010, 32'h8070_F0A5, rd, e, lat);
      for (int i = 0; i < 4; i++) begin
         do_req(1'b1, 1'b0, addrs[i], f3s[i], 32'h0, rd, e, lat);
         nchk++;
         if (rd !== exps[i] || e !== 1'b0) begin
            nfail++;
            $display("FAIL ext_load%0d: rdata=%h err=%b required %h 0", i, rd, e, exps[i]);
         end
      end
   endtask

   task automatic test_partial_store;
      logic [31:0] rd; logic e; int lat;
      do_req(1'b0, 1'b1, 32'h1000_0009, 3'b000, 32'h1234_5633, rd, e, lat);
      do_req(1'b1, 1'b0, 32'h1000_0008, 3'b010, 32'h0, rd, e, lat);
      nchk++;
      if (rd !== 32'h8070_33A5) begin
         nfail++;
         $display("FAIL partial_sb: rdata=%h required 807033A5", rd);
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic e; int lat;
      logic        rds [6];
      logic        wrs [6];
      logic [31:0] as  [6];
      logic [2:0]  fs  [6];
      rds = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      wrs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      as  = '{32'h1000_0002, 32'h1000_0001, 32'h0FFF_FFFC, 32'h1000_1000, 32'h1000_0004, 32'h1000_0004};
      fs  = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b010};
      for (int i = 0; i < 6; i++) begin
         do_req(rds[i], wrs[i], as[i], fs[i], 32'h0000_0000, rd, e, lat);
         nchk++;
         if (e !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
            nfail++;
            $display("FAIL err_case%0d: err=%b lat=%0d rdata=%h required 1 1 0", i, e, lat, rd);
         end
      end
      do_req(1'b1, 1'b0, 32'h1000_0004, 3'b010, 32'h0, rd, e, lat);
      nchk++;
      if (rd !== 32'hDEAD_BEEF) begin
         nfail++;
         $display("FAIL err_ram_kept_4: rdata=%h required DEADBEEF", rd);
      end
      do_req(1'b1, 1'b0, 32'h1000_0000, 3'b010, 32'h0, rd, e, lat);
      nchk++;
      if (rd !== model_load(32'h1000_0000, 3'b010) && mb.exists(0)) begin
         nfail++;
         $display("FAIL err_ram_kept_0: rdata=%h required %h", rd, model_load(32'h1000_0000, 3'b010));
      end
   endtask

   task automatic test_back_to_back;
      int aq[$];
      int vq[$];
      @(negedge clk);
      req_addr = 32'h1000_0004; req_funct3 = 3'b010; req_read = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c == 24) req_read = 1'b0;
         if (rsp_valid) begin
            vq.push_back(c);
            nchk++;
            if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
               nfail++;
               $display("FAIL b2b_data: rdata=%h err=%b required DEADBEEF 0", rsp_rdata, rsp_err);
            end
         end
         if (req_ready && req_read) aq.push_back(c);
         @(negedge clk);
      end
      nchk++;
      if (aq.size() != vq.size() || aq.size() < 5) begin
         nfail++;
         $display("FAIL b2b_count: accepts=%0d responses=%0d required equal and >=5", aq.size(), vq.size());
      end
      for (int i = 0; i < aq.size() && i < vq.size(); i++) begin
         nchk++;
         if (vq[i] != aq[i] + W + 2) begin
            nfail++;
            $display("FAIL b2b_latency%0d: rsp at %0d required %0d", i, vq[i], aq[i] + W + 2);
         end
         if (i > 0) begin
            nchk++;
            if (aq[i] - aq[i-1] != W + 3) begin
               nfail++;
               $display("FAIL b2b_spacing%0d: got %0d required %0d", i, aq[i] - aq[i-1], W + 3);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, a, wd, exp_rd; logic e, exp_e, r, w; logic [2:0] f3;
      int lat, k;
      logic [2:0] lf [5];
      lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < 16; i++)
         do_req(1'b0, 1'b1, BASE + 32'(4 * i), 3'b010, $urandom, rd, e, lat);
      do_req(1'b0, 1'b1, BASE + 32'd4092, 3'b010, $urandom, rd, e, lat);
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 15);
         r = (k == 0) || (k < 8);
         w = (k == 0) || (k >= 8);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
         else if (w)                    f3 = 3'($urandom_range(0, 2));
         else                           f3 = lf[$urandom_range(0, 4)];
         k = $urandom_range(0, 9);
         case (k)
            0:       a = BASE + 32'd4096 + 32'($urandom_range(0, 7));
            1:       a = BASE - 32'd4 + 32'($urandom_range(0, 3));
            2:       a = BASE + 32'd4092 + 32'($urandom_range(0, 3));
            default: a = BASE + 32'($urandom_range(0, 63));
         endcase
         wd = $urandom;
         exp_e  = model_err(r, w, a, f3);
         exp_rd = (exp_e || w) ? 32'h0 : model_load(a, f3);
         do_req(r, w, a, f3, wd, rd, e, lat);
         nchk++;
         if (e !== exp_e || lat != (exp_e ? 1 : W + 2) || rd !== exp_rd) begin
            nfail++;
            $display("FAIL rand%0d r=%b w=%b a=%h f3=%0d: err=%b lat=%0d rdata=%h required %b %0d %h",
                     i, r, w, a, f3, e, lat, rd, exp_e, exp_e ? 1 : W + 2, exp_rd);
         end
      end
   endtask

   task automatic test_reset_in_wait;
      logic [31:0] rd, exp_rd; logic e; int lat, seen;
      exp_rd = model_load(32'h1000_0004, 3'b010);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h1000_0004; req_funct3 = 3'b010; req_wdata = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      req_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nchk++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         nfail++;
         $display("FAIL rst_wait_ctrl: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      nchk++;
      if (seen != 0) begin
         nfail++;
         $display("FAIL rst_wait_norsp: %0d responses required 0", seen);
      end
      do_req(1'b1, 1'b0, 32'h1000_0004, 3'b010, 32'h0, rd, e, lat);
      nchk++;
      if (rd !== exp_rd) begin
         nfail++;
         $display("FAIL rst_wait_old_word: rdata=%h required %h", rd, exp_rd);
      end
   endtask

   task automatic test_reset_in_resp;
      logic [31:0] rd; int lat;
      do_req0(1'b0, 1'b1, 32'h1000_0010, 3'b010, 32'h0101_0101, rd, lat);
      nchk++;
      if (lat != 2) begin
         nfail++;
         $display("FAIL w0_latency: got %0d required 2", lat);
      end
      @(negedge clk);
      z_write = 1'b1; z_addr = 32'h1000_0010; z_f3 = 3'b010; z_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      z_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nchk++;
      if (z_valid !== 1'b1) begin
         nfail++;
         $display("FAIL w0_resp_cycle: valid=%b required 1", z_valid);
      end
      z_rst = 1'b1;
      @(negedge clk);
      z_rst = 1'b0;
      nchk++;
      if (z_ready !== 1'b1 || z_valid !== 1'b0) begin
         nfail++;
         $display("FAIL w0_rst_ctrl: ready=%b valid=%b required 1 0", z_ready, z_valid);
      end
      do_req0(1'b1, 1'b0, 32'h1000_0010, 3'b010, 32'h0, rd, lat);
      nchk++;
      if (rd !== 32'hCAFE_F00D || lat != 2) begin
         nfail++;
         $display("FAIL w0_committed: rdata=%h lat=%0d required CAFEF00D 2", rd, lat);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_extension();
      test_partial_store();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_in_wait();
      test_reset_in_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multicycle data-memory responder for the RV32I multicycle core. It is the memory end of the control unit's `DMemread`/`DMemWrite` strobes. It accepts one load or store request at a time and performs it against an internal word-organised RAM. Byte/half/word access and extension follow funct3. It returns a registered one-cycle response pulse with read data or an error flag.

## Interface
- `BASE_ADDR`, default `32'h1000_0000`: byte address of RAM word 0.
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, default 1: extra wait-state cycles before access; 0–15.
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous active-high reset.
- `req_read`, input, 1: load request; sampled only when `req_ready`=1.
- `req_write`, input, 1: store request; sampled only when `req_ready`=1.
- `req_addr`, input, 32: byte address.
- `req_funct3`, input, 3: RV32I load/store funct3.
- `req_wdata`, input, 32: store data, right-aligned.
- `req_ready`, output, 1: high in IDLE only.
- `rsp_valid`, output, 1: one-cycle response pulse.
- `rsp_rdata`, output, 32: extended load data; 0 for stores and errors.
- `rsp_err`, output, 1: qualifies `rsp_valid`; request rejected.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- **Accept:** a request is accepted on the clock edge where `req_ready`=1 and (`req_read`|`req_write`)=1. Address, funct3, wdata and direction are latched at that edge and the live inputs are ignored afterwards.
- **Error checks**, evaluated at acceptance on the latched values. The request is an error if any of the following holds:
  - both `req_read` and `req_write` are high;
  - read funct3 is not one of 000/001/010/100/101;
  - write funct3 is greater than 010;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - (`addr`−`BASE_ADDR`), computed in 32-bit unsigned with wrap, is ≥ `DEPTH_WORDS`×4.
- **Error path:** IDLE→RESP with `rsp_err`=1. RAM is untouched.
- **Legal path:** IDLE→WAIT. WAIT counts `WAIT_CYCLES` cycles, then goes to ACCESS. If `WAIT_CYCLES`=0, IDLE goes directly to ACCESS.
- **ACCESS** (one cycle):
  - Word index is (`addr`−`BASE_ADDR`)[log2(DEPTH)+1:2] and lane is `addr[1:0]`.
  - Store: SB writes `wdata[7:0]` to the lane's byte. SH writes `wdata[15:0]` to bytes 2·`addr[1]`+{0,1}. SW writes all 4 bytes. Other bytes of the word are preserved.
  - Load: the selected byte or half is sign-extended (LB, LH) or zero-extended (LBU, LHU). LW returns the full word.
  - Result is registered into `rsp_rdata`. ACCESS always goes to RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE. No backpressure; the requester must capture in that cycle.
- Requests presented outside IDLE are ignored; they are not queued.
- A store followed by a load to the same word returns the new data, because the write commits at the ACCESS edge.
- **Reset:** FSM goes to IDLE, wait counter to 0, `rsp_valid`/`rsp_err`=0, `rsp_rdata`=0, `req_ready`=1 in the cycle after reset. RAM contents are not reset.
- **Reset mid-operation:** the pending request is dropped with no response. A store is committed only if its ACCESS edge has already occurred.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Legal request accepted at edge 0: `rsp_valid` is high during cycle `WAIT_CYCLES`+2. With the default, that is 3 cycles after acceptance.
- Error request accepted at edge 0: `rsp_valid`=`rsp_err`=1 during cycle 1.
- `req_ready` drops the cycle after acceptance and returns the cycle after RESP. Maximum throughput is one request per `WAIT_CYCLES`+3 cycles.
- Store data is visible to a read at the earliest on the next accepted request.

## Structure
- **Shared package / defines header** (alongside the opcode defines):
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010;
  - the responder state encoding.
- **Sub-module `mem_lane_align`:** purely combinational, shared with the future instruction-side responder. It maps (funct3, `addr[1:0]`, wdata, rdata word) to a 4-bit byte-write strobe, the shifted store word, and the extended load value.
- The RAM is an inferred array in the top; no vendor primitive.

## Test plan
- **Word round-trip:** SW `addr=0x1000_0004`, wdata `0xDEAD_BEEF` → `rsp_valid` in cycle 3, `rsp_err`=0. Then LW at the same address → `rsp_rdata`=`0xDEAD_BEEF`.
- **Byte/half extension:** with word `0x8070_F0A5` at `0x1000_0008`:
  - LB `+0` → `0xFFFF_FFA5`;
  - LBU `+1` → `0x0000_00F0`;
  - LH `+2` → `0xFFFF_8070`;
  - LHU `+2` → `0x0000_8070`.
- **Partial store:** SB `0x1000_0009` wdata `0x1234_5633` over the word above → LW returns `0x8070_33A5`.
- **Errors**, each giving `rsp_err`=1 in cycle 1 with RAM unchanged:
  - LW `0x1000_0002`;
  - SH `0x1000_0001`;
  - LW `0x0FFF_FFFC`;
  - LW at `BASE`+4096 with DEPTH=1024;
  - funct3=011 load;
  - `req_read`=`req_write`=1.
- **Back-to-back:** hold `req_read` high continuously → a new request is accepted only while `req_ready`=1. Exactly one `rsp_valid` pulse per acceptance, spaced `WAIT_CYCLES`+3 cycles apart.
- **Reset mid-op:**
  - assert `rst` during WAIT of an SW → no `rsp_valid`, old word retained, `req_ready`=1 the cycle after reset;
  - repeat with `WAIT_CYCLES`=0 and reset in RESP → store is committed.
